// File: rtl/taillight_controller.sv
// Sequential tail light controller: cumulative outward turn sequence per side,
// hazard lockstep on both sides, steady brake on any side that is not sequencing.
module taillight_controller #(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brake,
  input  logic       turn_left,
  input  logic       turn_right,
  output logic [2:0] left_taillight_control,
  output logic [2:0] right_taillight_control
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  localparam logic [15:0] LP_LAST_STEP = 16'(STEP_CYCLES - 1);

  mode_t       r_mode;
  logic [1:0]  r_phase;
  logic [15:0] r_step_cnt;
  logic [2:0]  r_left;
  logic [2:0]  r_right;

  mode_t       w_mode_dec;
  mode_t       w_mode_nxt;
  logic [1:0]  w_phase_nxt;
  logic [15:0] w_step_cnt_nxt;
  logic [2:0]  w_left_nxt;
  logic [2:0]  w_right_nxt;

  function automatic logic [2:0] f_pattern(input logic [1:0] phase);
    logic [2:0] pat;
    case (phase)
      2'd0:    pat = 3'b001;
      2'd1:    pat = 3'b011;
      2'd2:    pat = 3'b111;
      default: pat = 3'b000;
    endcase
    return pat;
  endfunction

  // Decode the requested mode from the turn switches.
  always_comb begin
    w_mode_dec = MODE_IDLE;
    case ({turn_right, turn_left})
      2'b01:   w_mode_dec = MODE_LEFT;
      2'b10:   w_mode_dec = MODE_RIGHT;
      2'b11:   w_mode_dec = MODE_HAZARD;
      default: w_mode_dec = MODE_IDLE;
    endcase
  end

  // Next-state: a mode change restarts at 001, otherwise the prescaler paces the phase.
  always_comb begin
    w_mode_nxt     = r_mode;
    w_phase_nxt    = r_phase;
    w_step_cnt_nxt = r_step_cnt;
    if (w_mode_dec == MODE_IDLE) begin
      w_mode_nxt     = MODE_IDLE;
      w_phase_nxt    = 2'd0;
      w_step_cnt_nxt = 16'd0;
    end else if (w_mode_dec != r_mode) begin
      w_mode_nxt     = w_mode_dec;
      w_phase_nxt    = 2'd0;
      w_step_cnt_nxt = 16'd0;
    end else if (r_step_cnt == LP_LAST_STEP) begin
      w_phase_nxt    = r_phase + 2'd1;
      w_step_cnt_nxt = 16'd0;
    end else begin
      w_step_cnt_nxt = r_step_cnt + 16'd1;
    end
  end

  // Lamp patterns derived from the next state so outputs track inputs with one clock latency.
  always_comb begin
    w_left_nxt  = {3{brake}};
    w_right_nxt = {3{brake}};
    if ((w_mode_nxt == MODE_LEFT) || (w_mode_nxt == MODE_HAZARD)) begin
      w_left_nxt = f_pattern(w_phase_nxt);
    end else begin
      w_left_nxt = {3{brake}};
    end
    if ((w_mode_nxt == MODE_RIGHT) || (w_mode_nxt == MODE_HAZARD)) begin
      w_right_nxt = f_pattern(w_phase_nxt);
    end else begin
      w_right_nxt = {3{brake}};
    end
  end

  // State and lamp registers; reset blanks the lamps without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= MODE_IDLE;
      r_phase    <= 2'd0;
      r_step_cnt <= 16'd0;
      r_left     <= 3'b000;
      r_right    <= 3'b000;
    end else begin
      r_mode     <= w_mode_nxt;
      r_phase    <= w_phase_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_left     <= w_left_nxt;
      r_right    <= w_right_nxt;
    end
  end

  assign left_taillight_control  = r_left;
  assign right_taillight_control = r_right;

endmodule

// File: tb/tb_taillight_controller.sv
// Bench for taillight_controller: two instances (S=1, S=3) on shared inputs, checked against
// a run-length reference model under directed and random stimulus.
module tb_taillight_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       brake = 1'b0;
  logic       turn_left = 1'b0;
  logic       turn_right = 1'b0;
  logic [2:0] left1, right1, left3, right3;

  int total = 0;
  int bad   = 0;

  // Reference state: edges spent in the current non-idle mode and which mode that is.
  int         run_len = 0;
  logic [1:0] run_mode = 2'd0;
  logic [2:0] exp_l1 = 3'b000, exp_r1 = 3'b000, exp_l3 = 3'b000, exp_r3 = 3'b000;

  taillight_controller #(.STEP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
    .left_taillight_control(left1), .right_taillight_control(right1)
  );

  taillight_controller #(.STEP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
    .left_taillight_control(left3), .right_taillight_control(right3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] seq_pattern(input int len, input int s);
    logic [2:0] table_v [4];
    table_v[0] = 3'b001;
    table_v[1] = 3'b011;
    table_v[2] = 3'b111;
    table_v[3] = 3'b000;
    return table_v[(len / s) % 4];
  endfunction

  task automatic model_reset();
    run_len  = 0;
    run_mode = 2'd0;
    exp_l1 = 3'b000; exp_r1 = 3'b000; exp_l3 = 3'b000; exp_r3 = 3'b000;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_left_s1"},  left1,  exp_l1);
    check_eq({tag, "_right_s1"}, right1, exp_r1);
    check_eq({tag, "_left_s3"},  left3,  exp_l3);
    check_eq({tag, "_right_s3"}, right3, exp_r3);
  endtask

  // One clock edge: update the model from the sampled inputs, then check just after the edge.
  task automatic tick(input string tag);
    logic [1:0] m;
    bit         seq_l, seq_r;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m = {turn_right, turn_left};
      if (m == 2'd0) begin
        run_len = 0; run_mode = 2'd0;
      end else if (m != run_mode) begin
        run_len = 0; run_mode = m;
      end else begin
        run_len++;
      end
      seq_l = turn_left;
      seq_r = turn_right;
      exp_l1 = seq_l ? seq_pattern(run_len, 1) : {3{brake}};
      exp_r1 = seq_r ? seq_pattern(run_len, 1) : {3{brake}};
      exp_l3 = seq_l ? seq_pattern(run_len, 3) : {3{brake}};
      exp_r3 = seq_r ? seq_pattern(run_len, 3) : {3{brake}};
    end
    #1;
    check_all(tag);
  endtask

  task automatic assert_reset_async(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst = 1'b1;
    #2;
    model_reset();
    check_all("por_async");
    ticks(10, "reset_hold");
    rst = 1'b0;
    ticks(3, "idle");

    turn_left = 1'b1;
    ticks(20, "left_seq");
    turn_left = 1'b0;
    ticks(2, "left_drop");

    brake = 1'b1;
    ticks(3, "brake_only");
    turn_right = 1'b1;
    ticks(6, "brake_right");
    turn_right = 1'b0;
    ticks(2, "brake_right_drop");
    brake = 1'b0;

    turn_left = 1'b1;
    ticks(10, "pre_switch");
    turn_left = 1'b0; turn_right = 1'b1;
    tick("switch");
    check_eq("switch_right_is_001", right1, 3'b001);
    check_eq("switch_left_is_000", left1, 3'b000);
    ticks(2, "right_to_111");
    check_eq("right_at_111", right1, 3'b111);
    #2;
    assert_reset_async("mid_reset_async");
    ticks(2, "mid_reset_hold");
    #2;
    rst = 1'b0;
    tick("after_release");
    check_eq("release_right_001", right1, 3'b001);
    turn_right = 1'b0;
    tick("release_drop");

    turn_left = 1'b1; turn_right = 1'b1;
    ticks(24, "hazard");
    turn_left = 1'b0; turn_right = 1'b0;
    tick("hazard_drop");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        brake      = 1'($urandom_range(0, 1));
        turn_left  = 1'($urandom_range(0, 1));
        turn_right = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 59) == 0) begin
        assert_reset_async("rand_reset_async");
      end else begin
        rst = 1'b0;
      end
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
